// File: rtl/agc_pkg.sv
// Shared constants and saturation helpers for the I/Q automatic gain control loop.
package agc_pkg;

  // Number of fractional bits in the gain register.
  localparam int GFRAC = 10;

  // Unity gain in the gain register's fixed-point format.
  localparam int unsigned GAIN_RESET = 32'd1 << GFRAC;

  // Clamp a signed value into the two's-complement range of 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                    input int width);
    logic signed [63:0] max_s;
    logic signed [63:0] min_s;
    max_s = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_s = -max_s - 64'sd1;
    if (value > max_s) begin
      sat_signed = max_s;
    end else if (value < min_s) begin
      sat_signed = min_s;
    end else begin
      sat_signed = value;
    end
  endfunction

  // Clamp a signed value into the unsigned range [0, 2^width-1].
  function automatic logic signed [63:0] sat_unsigned(input logic signed [63:0] value,
                                                      input int width);
    logic signed [63:0] max_s;
    max_s = (64'sd1 <<< width) - 64'sd1;
    if (value < 64'sd0) begin
      sat_unsigned = 64'sd0;
    end else if (value > max_s) begin
      sat_unsigned = max_s;
    end else begin
      sat_unsigned = value;
    end
  endfunction

endpackage

// File: rtl/agc_iq_loop_if.sv
// Sample stream into the AGC and gain-scaled stream out of it.
interface agc_iq_loop_if #(
  parameter int W_IN        = 16,
  parameter int W_IN_MODULE = 26
);
  logic signed [W_IN-1:0]        s_chans_dataI;
  logic signed [W_IN-1:0]        s_chans_dataQ;
  logic                          s_chans_valid;
  logic                          Valid_Out;
  logic signed [W_IN_MODULE-1:0] OutputI;
  logic signed [W_IN_MODULE-1:0] OutputQ;

  modport master (
    output s_chans_dataI, s_chans_dataQ, s_chans_valid,
    input  Valid_Out, OutputI, OutputQ
  );

  modport slave (
    input  s_chans_dataI, s_chans_dataQ, s_chans_valid,
    output Valid_Out, OutputI, OutputQ
  );
endinterface

// File: rtl/agc_loop_filter.sv
// Level detector, first-order level smoother, error and gain update of the AGC loop.
// Every stage carries its own valid bit and its own copy of the coefficients
// sampled with the sample, so overlapping samples update in order.
module agc_loop_filter
  import agc_pkg::*;
#(
  parameter int W_IN        = 16,
  parameter int W_IN_MODULE = 26,
  parameter int BWIDTH      = 18,
  parameter int FILTERWIDTH = 13,
  parameter int AWIDTH      = 30,
  parameter int DWIDTH      = 27,
  parameter int RWIDTH      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          y_valid,
  input  logic signed [W_IN_MODULE-1:0] y_i,
  input  logic signed [W_IN_MODULE-1:0] y_q,
  input  logic [FILTERWIDTH-1:0]        alpha,
  input  logic [FILTERWIDTH-1:0]        mu,
  input  logic [RWIDTH-1:0]             rlev,
  output logic [BWIDTH-1:0]             g
);
  localparam int LW    = AWIDTH - FILTERWIDTH;
  localparam int SHIFT = W_IN - RWIDTH;
  localparam int APW   = AWIDTH + FILTERWIDTH + 3;
  localparam int GPW   = DWIDTH + FILTERWIDTH + 1;

  logic                     v2_r, v3_r, v4_r;
  logic [LW-1:0]            a_r;
  logic [AWIDTH-1:0]        avg_r;
  logic signed [DWIDTH-1:0] e_r;
  logic [BWIDTH-1:0]        g_r;
  logic [FILTERWIDTH-1:0]   alpha2_r, mu2_r, mu3_r, mu4_r;
  logic [RWIDTH-1:0]        r2_r, r3_r;

  logic signed [W_IN_MODULE:0] yi_ext_s, yq_ext_s;
  logic [W_IN_MODULE:0]        abs_i_s, abs_q_s;
  logic [W_IN_MODULE+1:0]      mag_s;
  logic [LW-1:0]               level_s;
  logic signed [AWIDTH+1:0]    diff_s;
  logic signed [APW-1:0]       avg_prod_s;
  logic [AWIDTH-1:0]           avg_next_s;
  logic signed [DWIDTH-1:0]    err_next_s;
  logic signed [GPW-1:0]       g_prod_s;
  logic signed [63:0]          g_sum_s;
  logic [BWIDTH-1:0]           g_next_s;

  // Datapath for all loop stages; a lower gain bound of 1 keeps the loop alive.
  always_comb begin
    yi_ext_s   = (W_IN_MODULE + 1)'(y_i);
    yq_ext_s   = (W_IN_MODULE + 1)'(y_q);
    abs_i_s    = yi_ext_s[W_IN_MODULE] ? -yi_ext_s : yi_ext_s;
    abs_q_s    = yq_ext_s[W_IN_MODULE] ? -yq_ext_s : yq_ext_s;
    mag_s      = {1'b0, abs_i_s} + {1'b0, abs_q_s};
    level_s    = LW'(sat_unsigned(64'(mag_s >> SHIFT), LW - 1));
    diff_s     = $signed({2'b00, a_r, {FILTERWIDTH{1'b0}}}) - $signed({2'b00, avg_r});
    avg_prod_s = APW'($signed({1'b0, alpha2_r})) * APW'(diff_s);
    avg_next_s = AWIDTH'(sat_unsigned(64'($signed({1'b0, avg_r})) +
                                      64'(avg_prod_s >>> FILTERWIDTH), AWIDTH));
    err_next_s = DWIDTH'(sat_signed(64'($signed({1'b0, r3_r, {FILTERWIDTH{1'b0}}})) -
                                    64'($signed({1'b0, avg_r})), DWIDTH));
    g_prod_s   = GPW'($signed({1'b0, mu4_r})) * GPW'(e_r);
    g_sum_s    = 64'($signed({1'b0, g_r})) + 64'(g_prod_s >>> (2 * FILTERWIDTH - GFRAC));
    if (g_sum_s < 64'sd1) begin
      g_next_s = {{(BWIDTH - 1){1'b0}}, 1'b1};
    end else begin
      g_next_s = BWIDTH'(sat_unsigned(g_sum_s, BWIDTH));
    end
  end

  // Level detection of the scaled output sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r     <= 1'b0;
      a_r      <= {LW{1'b0}};
      alpha2_r <= {FILTERWIDTH{1'b0}};
      mu2_r    <= {FILTERWIDTH{1'b0}};
      r2_r     <= {RWIDTH{1'b0}};
    end else begin
      v2_r <= y_valid;
      if (y_valid) begin
        a_r      <= level_s;
        alpha2_r <= alpha;
        mu2_r    <= mu;
        r2_r     <= rlev;
      end
    end
  end

  // First-order smoothing of the detected level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_r  <= 1'b0;
      avg_r <= {AWIDTH{1'b0}};
      mu3_r <= {FILTERWIDTH{1'b0}};
      r3_r  <= {RWIDTH{1'b0}};
    end else begin
      v3_r <= v2_r;
      if (v2_r) begin
        avg_r <= avg_next_s;
        mu3_r <= mu2_r;
        r3_r  <= r2_r;
      end
    end
  end

  // Error between reference and smoothed level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v4_r  <= 1'b0;
      e_r   <= {DWIDTH{1'b0}};
      mu4_r <= {FILTERWIDTH{1'b0}};
    end else begin
      v4_r <= v3_r;
      if (v3_r) begin
        e_r   <= err_next_s;
        mu4_r <= mu3_r;
      end
    end
  end

  // Gain register update from the weighted error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r <= BWIDTH'(GAIN_RESET);
    end else if (v4_r) begin
      g_r <= g_next_s;
    end
  end

  assign g = g_r;

endmodule

// File: rtl/agc_iq_loop.sv
// Feedback AGC for one I/Q channel: captures samples, scales them by the loop
// gain, registers the saturated result and feeds it to the loop filter.
module agc_iq_loop
  import agc_pkg::*;
#(
  parameter int W_IN        = 16,
  parameter int W_IN_MODULE = 26,
  parameter int BWIDTH      = 18,
  parameter int FILTERWIDTH = 13,
  parameter int AWIDTH      = 30,
  parameter int DWIDTH      = 27,
  parameter int RWIDTH      = 8,
  parameter int DSPWIDTH    = 48,
  parameter int W_OUT       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  agc_iq_loop_if.slave           chans,
  input  logic [FILTERWIDTH-1:0] Filter_Coefficient,
  input  logic [FILTERWIDTH-1:0] Error_Coefficient,
  input  logic [RWIDTH-1:0]      R_level
);
  localparam int PROD_W = W_IN + BWIDTH + 1;

  if ((W_OUT > W_IN_MODULE) || (PROD_W > DSPWIDTH)) begin : g_param_check
    $error("agc_iq_loop: W_OUT or product width out of range");
  end

  logic                          v0_r;
  logic signed [W_IN-1:0]        xi_r, xq_r;
  logic [FILTERWIDTH-1:0]        alpha0_r, mu0_r, alpha1_r, mu1_r;
  logic [RWIDTH-1:0]             rlev0_r, rlev1_r;
  logic [BWIDTH-1:0]             gain_s;
  logic signed [PROD_W-1:0]      prod_i_s, prod_q_s;
  logic signed [W_IN_MODULE-1:0] y_i_s, y_q_s;

  // Capture the sample and the coefficients that travel with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r     <= 1'b0;
      xi_r     <= {W_IN{1'b0}};
      xq_r     <= {W_IN{1'b0}};
      alpha0_r <= {FILTERWIDTH{1'b0}};
      mu0_r    <= {FILTERWIDTH{1'b0}};
      rlev0_r  <= {RWIDTH{1'b0}};
    end else begin
      v0_r <= chans.s_chans_valid;
      if (chans.s_chans_valid) begin
        xi_r     <= chans.s_chans_dataI;
        xq_r     <= chans.s_chans_dataQ;
        alpha0_r <= Filter_Coefficient;
        mu0_r    <= Error_Coefficient;
        rlev0_r  <= R_level;
      end
    end
  end

  // Scale by the current gain, floor the fraction and saturate to the output width.
  always_comb begin
    prod_i_s = PROD_W'(xi_r) * PROD_W'($signed({1'b0, gain_s}));
    prod_q_s = PROD_W'(xq_r) * PROD_W'($signed({1'b0, gain_s}));
    y_i_s    = W_IN_MODULE'(sat_signed(64'(prod_i_s >>> GFRAC), W_IN_MODULE));
    y_q_s    = W_IN_MODULE'(sat_signed(64'(prod_q_s >>> GFRAC), W_IN_MODULE));
  end

  // Output registers; Valid_Out is a one-cycle strobe per captured sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chans.Valid_Out <= 1'b0;
      chans.OutputI   <= {W_IN_MODULE{1'b0}};
      chans.OutputQ   <= {W_IN_MODULE{1'b0}};
      alpha1_r        <= {FILTERWIDTH{1'b0}};
      mu1_r           <= {FILTERWIDTH{1'b0}};
      rlev1_r         <= {RWIDTH{1'b0}};
    end else begin
      chans.Valid_Out <= v0_r;
      if (v0_r) begin
        chans.OutputI <= y_i_s;
        chans.OutputQ <= y_q_s;
        alpha1_r      <= alpha0_r;
        mu1_r         <= mu0_r;
        rlev1_r       <= rlev0_r;
      end
    end
  end

  agc_loop_filter #(
    .W_IN        (W_IN),
    .W_IN_MODULE (W_IN_MODULE),
    .BWIDTH      (BWIDTH),
    .FILTERWIDTH (FILTERWIDTH),
    .AWIDTH      (AWIDTH),
    .DWIDTH      (DWIDTH),
    .RWIDTH      (RWIDTH)
  ) u_loop (
    .clk     (clk),
    .rst     (rst),
    .y_valid (chans.Valid_Out),
    .y_i     (chans.OutputI),
    .y_q     (chans.OutputQ),
    .alpha   (alpha1_r),
    .mu      (mu1_r),
    .rlev    (rlev1_r),
    .g       (gain_s)
  );

endmodule

// File: tb/tb_agc_iq_loop.sv
// Directed bench for agc_iq_loop with hand-computed expectations.
module tb_agc_iq_loop;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] filter_coef;
  logic [12:0] error_coef;
  logic [7:0]  r_level;

  int n_checks = 0;
  int n_pass   = 0;
  int vo_count = 0;
  longint cap_i [0:63];
  longint cap_q [0:63];

  always #5 clk = ~clk;

  agc_iq_loop_if #(.W_IN(16), .W_IN_MODULE(26)) chans ();

  agc_iq_loop dut (
    .clk                (clk),
    .rst                (rst),
    .chans              (chans),
    .Filter_Coefficient (filter_coef),
    .Error_Coefficient  (error_coef),
    .R_level            (r_level)
  );

  // Record every output strobe with its data.
  always @(negedge clk) begin
    if (chans.Valid_Out === 1'b1) begin
      cap_i[vo_count % 64] = longint'(chans.OutputI);
      cap_q[vo_count % 64] = longint'(chans.OutputQ);
      vo_count = vo_count + 1;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint gain_now();
    return longint'(dut.gain_s);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    chans.s_chans_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One sample with 40-cycle spacing; returns what is on the outputs two edges later.
  task automatic send(input int xi, input int xq, input int al, input int mu, input int rl,
                      output longint oi, output longint oq, output longint vo);
    @(negedge clk);
    chans.s_chans_dataI = 16'(xi);
    chans.s_chans_dataQ = 16'(xq);
    chans.s_chans_valid = 1'b1;
    filter_coef = 13'(al);
    error_coef  = 13'(mu);
    r_level     = 8'(rl);
    @(negedge clk);
    chans.s_chans_valid = 1'b0;
    @(negedge clk);
    vo = longint'(chans.Valid_Out);
    oi = longint'(chans.OutputI);
    oq = longint'(chans.OutputQ);
    repeat (37) @(negedge clk);
  endtask

  // A sample followed by reset 'dly' cycles after its strobe.
  task automatic pulse_then_reset(input int dly, input int xi, input int xq);
    @(negedge clk);
    chans.s_chans_dataI = 16'(xi);
    chans.s_chans_dataQ = 16'(xq);
    chans.s_chans_valid = 1'b1;
    filter_coef = 13'd4096;
    error_coef  = 13'd64;
    r_level     = 8'd16;
    for (int k = 1; k <= dly; k++) begin
      @(negedge clk);
      chans.s_chans_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    longint oi, oq, vo, lvl, ai, aq;
    int base;

    rst = 1'b0;
    chans.s_chans_dataI = 16'sd0;
    chans.s_chans_dataQ = 16'sd0;
    chans.s_chans_valid = 1'b0;
    filter_coef = 13'd0;
    error_coef  = 13'd0;
    r_level     = 8'd0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid_out", longint'(chans.Valid_Out), 0);
    chk("rst_out_i", longint'(chans.OutputI), 0);
    chk("rst_out_q", longint'(chans.OutputQ), 0);
    chk("rst_gain", gain_now(), 1024);
    rst = 1'b0;

    // 1: unity gain pass-through, frozen gain
    send(1000, -500, 4096, 0, 16, oi, oq, vo);
    chk("t1_valid", vo, 1);
    chk("t1_out_i", oi, 1000);
    chk("t1_out_q", oq, -500);
    chk("t1_gain", gain_now(), 1024);

    // 2: gain growth with zero input
    do_reset();
    send(0, 0, 4096, 64, 16, oi, oq, vo);
    chk("t2_out_i", oi, 0);
    chk("t2_gain1", gain_now(), 1152);
    send(0, 0, 4096, 64, 16, oi, oq, vo);
    chk("t2_gain2", gain_now(), 1280);

    // 3: convergence to the reference level
    do_reset();
    for (int n = 0; n < 200; n++) begin
      send(8192, 0, 4096, 256, 32, oi, oq, vo);
      if (n >= 180) begin
        ai  = (oi < 0) ? -oi : oi;
        aq  = (oq < 0) ? -oq : oq;
        lvl = (ai + aq) >>> 8;
        chk("t3_level_in_band", longint'(lvl >= 31 && lvl <= 33), 1);
        chk("t3_gain_in_band", longint'(gain_now() >= 992 && gain_now() <= 1056), 1);
      end
    end

    // 4: gain clamps at 1 with zero reference
    do_reset();
    send(32767, 32767, 8191, 8191, 0, oi, oq, vo);
    chk("t4_out_i0", oi, 32767);
    chk("t4_out_q0", oq, 32767);
    chk("t4_gain0", gain_now(), 1);
    for (int n = 0; n < 5; n++) begin
      send(32767, 32767, 8191, 8191, 0, oi, oq, vo);
      chk("t4_out_i", oi, 31);
      chk("t4_out_q", oq, 31);
      chk("t4_gain", gain_now(), 1);
    end

    // 5: gain clamps at max, full-scale outputs stay in range
    do_reset();
    send(0, 0, 4096, 8191, 255, oi, oq, vo);
    chk("t5_gain1", gain_now(), 262112);
    send(0, 0, 4096, 8191, 255, oi, oq, vo);
    chk("t5_gain2", gain_now(), 262143);
    send(32767, -32768, 4096, 0, 255, oi, oq, vo);
    chk("t5_out_i", oi, 8388320);
    chk("t5_out_q", oq, -8388576);
    chk("t5_gain3", gain_now(), 262143);

    // 6a: reset before the output strobe kills the sample
    do_reset();
    base = vo_count;
    pulse_then_reset(1, 1000, -500);
    chk("t6a_no_valid", longint'(vo_count - base), 0);
    chk("t6a_out_i", longint'(chans.OutputI), 0);
    chk("t6a_gain", gain_now(), 1024);

    // 6b: reset 3 cycles after the strobe discards the pending gain update
    base = vo_count;
    pulse_then_reset(3, 1000, -500);
    chk("t6b_one_valid", longint'(vo_count - base), 1);
    chk("t6b_out_i", longint'(chans.OutputI), 0);
    chk("t6b_out_q", longint'(chans.OutputQ), 0);
    chk("t6b_gain", gain_now(), 1024);
    send(1000, -500, 4096, 0, 16, oi, oq, vo);
    chk("t6_valid", vo, 1);
    chk("t6_out_i", oi, 1000);
    chk("t6_out_q", oq, -500);
    chk("t6_gain", gain_now(), 1024);

    // 7: back-to-back strobes each yield one output, in order
    do_reset();
    base = vo_count;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      chans.s_chans_dataI = 16'(100 * n);
      chans.s_chans_dataQ = 16'(-n);
      chans.s_chans_valid = 1'b1;
      filter_coef = 13'd4096;
      error_coef  = 13'd0;
      r_level     = 8'd16;
    end
    @(negedge clk);
    chans.s_chans_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("t7_count", longint'(vo_count - base), 3);
    for (int n = 0; n < 3; n++) begin
      chk("t7_out_i", cap_i[(base + n) % 64], longint'(100 * (n + 1)));
      chk("t7_out_q", cap_q[(base + n) % 64], longint'(-(n + 1)));
    end
    chk("t7_gain", gain_now(), 1024);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
